// File: rtl/mips_pc_ras_pkg.sv
// Shared fetch-PC definitions: PC action encodings and their width.
// Exception redirect is enabled in the PC unit by defining MIPS_PC_RAS_EXC_EN.
package mips_pc_ras_pkg;

  localparam int unsigned ACTION_W = 3;

  // Encodings 0-4 match the original PC unit; 5-7 add call/return.
  typedef enum logic [ACTION_W-1:0] {
    ACT_NONE   = 3'd0,
    ACT_INC    = 3'd1,
    ACT_BRANCH = 3'd2,
    ACT_JUMP   = 3'd3,
    ACT_JUMPR  = 3'd4,
    ACT_CALL   = 3'd5,
    ACT_CALLR  = 3'd6,
    ACT_RETURN = 3'd7
  } mips_control_signal_pc_signal_action_e;

endpackage

// File: rtl/mips_pc_ras_stack.sv
// Circular return-address stack: when full, a push overwrites the oldest entry.
// Overflow and underflow are registered one-cycle pulses.
module mips_pc_ras_stack
  import mips_pc_ras_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty, full;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ptr_dec     = ptr_q - PTR_W'(1);
  assign top_data_o  = mem_q[ptr_dec];
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage needs no reset; count/pointer gate every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mips_pc_ras_unit.sv
// Fetch program counter with call/return prediction through a return-address stack.
// Define MIPS_PC_RAS_EXC_EN to add the exc_i/epc_o exception redirect.
module mips_pc_ras_unit
  import mips_pc_ras_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       OFFSET_W   = 16,
  parameter int unsigned       JUMP_W     = 26,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       SKIP       = $clog2(STEP),
  parameter logic [ADDR_W-1:0] RESET      = 32'h0040_0000,
  parameter int unsigned       RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic [ACTION_W-1:0] action_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [JUMP_W-1:0]   jump_i,
  input  logic [ADDR_W-1:0]   jumpr_i,
`ifdef MIPS_PC_RAS_EXC_EN
  input  logic                exc_i,
  output logic [ADDR_W-1:0]   epc_o,
`endif
  output logic [ADDR_W-1:0]   addr_next_o,
  output logic [ADDR_W-1:0]   addr_curr_o,
  output logic                ras_empty_o,
  output logic                ras_full_o,
  output logic                ras_overflow_o,
  output logic                ras_underflow_o
);

  logic [ADDR_W-1:0] addr_curr_q, addr_next;
  logic [ADDR_W-1:0] link, off, jump_tgt, ras_top;
  logic              push, pop, ras_empty;

  assign link     = addr_curr_q + ADDR_W'(STEP);
  assign off      = {{(ADDR_W-OFFSET_W){offset_i[OFFSET_W-1]}}, offset_i} << SKIP;
  assign jump_tgt = {addr_curr_q[ADDR_W-1:JUMP_W+SKIP], jump_i, {SKIP{1'b0}}};

  // Next-address select; at most one stack operation per cycle.
  always_comb begin
    addr_next = addr_curr_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (!stall_i) begin
      case (action_i)
        ACT_NONE:   addr_next = addr_curr_q;
        ACT_INC:    addr_next = link;
        ACT_BRANCH: addr_next = link + off;
        ACT_JUMP:   addr_next = jump_tgt;
        ACT_JUMPR:  addr_next = jumpr_i;
        ACT_CALL:   begin addr_next = jump_tgt; push = 1'b1; end
        ACT_CALLR:  begin addr_next = jumpr_i;  push = 1'b1; end
        ACT_RETURN: begin addr_next = ras_empty ? jumpr_i : ras_top; pop = 1'b1; end
        default:    addr_next = addr_curr_q;
      endcase
    end
`ifdef MIPS_PC_RAS_EXC_EN
    if (exc_i) begin
      addr_next = EXC_VECTOR;
      push      = 1'b0;
      pop       = 1'b0;
    end
`endif
    if (rst_i) addr_next = RESET;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) addr_curr_q <= RESET;
    else       addr_curr_q <= addr_next;
  end

`ifdef MIPS_PC_RAS_EXC_EN
  logic [ADDR_W-1:0] epc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      epc_q <= '0;
    else if (exc_i) epc_q <= addr_curr_q;
  end

  assign epc_o = epc_q;
`endif

  mips_pc_ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_stack (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(link),
    .top_data_o (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full_o),
    .overflow_o (ras_overflow_o),
    .underflow_o(ras_underflow_o)
  );

  assign addr_next_o = addr_next;
  assign addr_curr_o = addr_curr_q;
  assign ras_empty_o = ras_empty;

endmodule
